sort_engine: RTL and testbench
==============================

Name: sort_engine

Overview:
- Parametrised in-place bubble-sort engine; the next generation of the board-level sort block.
- Holds DEPTH words of WIDTH bits in a register array. Sorts them ascending or descending, signed or unsigned, at one compare per cycle.
- Reports the busy-cycle count and the swap count. Exposes a wrap-around view pointer with prior/next stepping for the debug/display unit.
- Sits between the debounced button pulses and the debug unit's tdin mux.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 8: number of entries, ≥2; need not be a power of two.
- SIGNED, 0: 1 = two's-complement compare, 0 = unsigned compare.
- CNT_W, 32: width of count and swaps; saturate at all-ones.
- AW, $clog2(DEPTH): address/pointer width (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begin sort
- up  in  1  1 = ascending, 0 = descending; sampled on accepted start
- wr_en  in  1  load strobe
- wr_addr  in  AW  load address
- wr_data  in  WIDTH  load data
- prior  in  1  single-cycle pulse; point−1
- next  in  1  single-cycle pulse; point+1
- busy  out  1  sort in progress
- done  out  1  sort finished; held until next start, load or reset
- point  out  AW  current view index
- data0  out  WIDTH  mem[point], combinational read
- count  out  CNT_W  busy cycles of last or current sort
- swaps  out  CNT_W  swaps performed in last or current sort

Behaviour:
- Reset (rst=1 at edge):
  - all mem entries = 0; point = 0; count = 0; swaps = 0; busy = 0; done = 0; FSM = IDLE.
  - Reset overrides everything, including mid-sort.
- FSM has three states: IDLE, SCAN, DONE.
  - busy = (state == SCAN).
  - done = (state == DONE).
- Load:
  - wr_en in IDLE or DONE writes mem[wr_addr] = wr_data at the edge.
  - Writing in DONE moves the FSM to IDLE (done drops the next cycle).
  - wr_addr ≥ DEPTH is ignored.
  - wr_en while busy is ignored.
- Start acceptance:
  - start in IDLE or DONE is accepted. At that edge: latch up; j = 0; limit = DEPTH−1; count = 0; swaps = 0; pass_swapped = 0; go to SCAN.
  - If start and wr_en arrive in the same cycle, start wins and the write is dropped.
  - start while busy is ignored.
- SCAN (one compare per cycle, j from 0 to limit−1):
  - Compare a = mem[j], b = mem[j+1] (signed when SIGNED=1).
  - Out of order means: a > b when up=1; a < b when up=0. Swap only when strictly out of order (stable sort).
  - On a swap: both entries are rewritten in the same edge; swaps++; pass_swapped = 1.
  - count++ every SCAN cycle.
  - End of pass (j == limit−1):
    - If limit == 1, go to DONE.
    - Otherwise: limit--; j = 0; pass_swapped cleared. No bubble cycle between passes.
- Latency:
  - Full sort: exactly DEPTH·(DEPTH−1)/2 SCAN cycles; count equals that value.
  - done is high the cycle after the last compare.
- Saturation: count and swaps hold at 2^CNT_W − 1.
- View pointer:
  - next alone: point = (point == DEPTH−1) ? 0 : point+1.
  - prior alone: point = (point == 0) ? DEPTH−1 : point−1.
  - prior and next in the same cycle: no change.
  - Stepping is allowed in every state; data0 shows live contents during SCAN.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined: at end of pass, if pass_swapped == 0 (including the swap decision of the final compare), go to DONE immediately. An already-sorted input finishes in DEPTH−1 cycles.
- Undefined: always runs all DEPTH·(DEPTH−1)/2 compares. pass_swapped logic is absent.

Decomposition:
- Package sort_pkg holds:
  - state enum sort_state_t {IDLE, SCAN, DONE};
  - function cmp_out_of_order(a, b, up, signed_mode).
- One natural sub-module, sort_view_ptr: the wrap-around prior/next pointer, parametrised on DEPTH.
- The FSM, array and counters stay in sort_engine.

Test Plan (defaults unless noted):
- Reverse input, ascending:
  - Load mem = {7,6,5,4,3,2,1,0}, up=1, start.
  - Result: busy for 28 cycles; mem = {0..7}; count = 28; swaps = 28; done = 1 on cycle 29.
- Sorted input, with and without early exit:
  - Load {0..7}, up=1, start.
  - Without SORT_EARLY_EXIT_EN: count = 28, swaps = 0.
  - With SORT_EARLY_EXIT_EN: count = 7, swaps = 0.
- Signed compare:
  - SIGNED=1, DEPTH=4, load {1, 0xFFFFFFFF, 0x80000000, 0}, up=1.
  - Result: mem = {0x80000000, 0xFFFFFFFF, 0, 1}.
  - Same load with SIGNED=0: mem = {0, 1, 0x80000000, 0xFFFFFFFF}.
- Descending, stability, and collisions:
  - Load {3,3,1,5,...}, up=0. Result: non-increasing order.
  - wr_en during busy: no effect.
  - start + wr_en in the same idle cycle: sort runs and the write is dropped.
- Pointer:
  - From point=0: prior gives 7 and data0 = mem[7]; next gives 0.
  - prior+next together: point unchanged.
  - DEPTH=5: next from 4 gives 0.
- Reset mid-sort:
  - Assert rst at SCAN cycle 10.
  - Next cycle: busy = 0, done = 0, count = 0, swaps = 0, point = 0, all mem = 0.
  - A subsequent load + start sorts correctly.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and the compare helper for the in-place bubble sort engine.
// Compare operands are widened to CMP_W bits, so WIDTH must not exceed CMP_W.
package sort_pkg;

  localparam int CMP_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  function automatic logic cmp_out_of_order(input logic [CMP_W-1:0] a,
                                            input logic [CMP_W-1:0] b,
                                            input logic             up,
                                            input logic             signed_mode);
    logic gt, lt;
    if (signed_mode) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return up ? gt : lt;
  endfunction

endpackage

// File: rtl/sort_view_ptr.sv
// Wrap-around view index stepped by prior/next pulses; simultaneous pulses cancel.
module sort_view_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prior,
  input  logic          next,
  output logic [AW-1:0] point
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst)
      point <= '0;
    else if (next && !prior)
      point <= (point == LAST) ? '0 : point + AW'(1);
    else if (prior && !next)
      point <= (point == '0) ? LAST : point - AW'(1);
  end

endmodule

// File: rtl/sort_engine.sv
// In-place bubble sort over a register array, one compare per cycle, with
// busy-cycle/swap counters. Define SORT_EARLY_EXIT_EN to stop after a clean pass.
module sort_engine
  import sort_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             prior,
  input  logic             next,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    point,
  output logic [WIDTH-1:0] data0,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] swaps
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  sort_state_t state, state_nxt;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]    j, limit;
  logic             up_q;
  logic [CNT_W-1:0] count_q, swaps_q;
  logic [WIDTH-1:0] a, b;
  logic [CMP_W-1:0] a_x, b_x;
  logic             can_load, start_acc, wr_acc, swap, pass_end, finish;

  assign can_load  = (state != SCAN);
  assign start_acc = start && can_load;
  // start wins over a same-cycle write; out-of-range addresses are dropped
  assign wr_acc    = wr_en && can_load && !start && ({1'b0, wr_addr} < DEPTH_W);

  assign a = mem[j];
  assign b = mem[j + AW'(1)];

  always_comb begin
    if (SIGNED) begin
      a_x = CMP_W'($signed(a));
      b_x = CMP_W'($signed(b));
    end else begin
      a_x = CMP_W'(a);
      b_x = CMP_W'(b);
    end
  end

  assign swap     = (state == SCAN) && cmp_out_of_order(a_x, b_x, up_q, SIGNED);
  assign pass_end = (j == limit - AW'(1));

`ifdef SORT_EARLY_EXIT_EN
  logic pass_swapped;
  // the current compare's swap counts toward this pass's dirty flag
  assign finish = pass_end && ((limit == AW'(1)) || !(pass_swapped || swap));

  always_ff @(posedge clk) begin
    if (rst)                               pass_swapped <= 1'b0;
    else if (start_acc)                    pass_swapped <= 1'b0;
    else if (state == SCAN && pass_end)    pass_swapped <= 1'b0;
    else if (swap)                         pass_swapped <= 1'b1;
  end
`else
  assign finish = pass_end && (limit == AW'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (finish) state_nxt = DONE;
      DONE:    if (start) state_nxt = SCAN;
               else if (wr_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      j       <= '0;
      limit   <= '0;
      up_q    <= 1'b0;
      count_q <= '0;
      swaps_q <= '0;
    end else if (start_acc) begin
      up_q    <= up;
      j       <= '0;
      limit   <= LAST;
      count_q <= '0;
      swaps_q <= '0;
    end else if (state == SCAN) begin
      count_q <= count_q + CNT_W'(!(&count_q));
      if (swap) begin
        mem[j]          <= b;
        mem[j + AW'(1)] <= a;
        swaps_q         <= swaps_q + CNT_W'(!(&swaps_q));
      end
      if (pass_end) begin
        limit <= limit - AW'(1);
        j     <= '0;
      end else begin
        j <= j + AW'(1);
      end
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  sort_view_ptr #(.DEPTH(DEPTH), .AW(AW)) u_view (
    .clk   (clk),
    .rst   (rst),
    .prior (prior),
    .next  (next),
    .point (point)
  );

  assign busy  = (state == SCAN);
  assign done  = (state == DONE);
  assign data0 = mem[point];
  assign count = count_q;
  assign swaps = swaps_q;

endmodule

// File: tb/tb_sort_engine.sv
// Scoreboard bench for sort_engine: expected arrays/counts are queued at start and
// compared when done rises; side instances cover signed compare and DEPTH=5 wrap.
module tb_sort_engine;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance, DEPTH=8 unsigned
  logic        start, up, wr_en, prior, next;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [2:0]  point;
  logic [31:0] data0, count, swaps;

  sort_engine #(.WIDTH(32), .DEPTH(8)) u_main (
    .clk(clk), .rst(rst), .start(start), .up(up), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .prior(prior), .next(next), .busy(busy), .done(done),
    .point(point), .data0(data0), .count(count), .swaps(swaps)
  );

  // DEPTH=4 signed and unsigned instances sharing stimulus
  logic        s_start, s_up, s_wr_en, s_prior, s_next;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        sg_busy, sg_done, un_busy, un_done;
  logic [1:0]  sg_point, un_point;
  logic [31:0] sg_data0, sg_count, sg_swaps, un_data0, un_count, un_swaps;

  sort_engine #(.WIDTH(32), .DEPTH(4), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .start(s_start), .up(s_up), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .prior(s_prior), .next(s_next), .busy(sg_busy), .done(sg_done),
    .point(sg_point), .data0(sg_data0), .count(sg_count), .swaps(sg_swaps)
  );

  sort_engine #(.WIDTH(32), .DEPTH(4), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(s_start), .up(s_up), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .prior(s_prior), .next(s_next), .busy(un_busy), .done(un_done),
    .point(un_point), .data0(un_data0), .count(un_count), .swaps(un_swaps)
  );

  // DEPTH=5 instance, pointer wrap only
  logic        d_prior, d_next, d_busy, d_done;
  logic [2:0]  d_point;
  logic [7:0]  d_data0;
  logic [31:0] d_count, d_swaps;

  sort_engine #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .start(1'b0), .up(1'b0), .wr_en(1'b0), .wr_addr(3'd0),
    .wr_data(8'd0), .prior(d_prior), .next(d_next), .busy(d_busy), .done(d_done),
    .point(d_point), .data0(d_data0), .count(d_count), .swaps(d_swaps)
  );

  typedef struct {
    logic [31:0] mem [D];
    int          count;
    int          swaps;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tb_mem [D];
  int          pt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic ooo(input logic [31:0] x, input logic [31:0] y, input logic up_v);
    return up_v ? (x > y) : (x < y);
  endfunction

  // Expected result: insertion sort for data, inversion count for swaps,
  // pass count from the largest left-side displacement for early exit.
  function automatic exp_t model(input logic up_v);
    exp_t        e;
    logic [31:0] v [D];
    logic [31:0] tmp;
    int          k, need, passes;
    v = tb_mem;
    e.swaps = 0;
    need = 0;
    for (int i = 0; i < D; i++) begin
      int left = 0;
      for (int m = 0; m < i; m++) if (ooo(v[m], v[i], up_v)) left++;
      e.swaps += left;
      if (left > need) need = left;
    end
    for (int i = 1; i < D; i++) begin
      tmp = v[i];
      k = i;
      while (k > 0 && ooo(v[k-1], tmp, up_v)) begin
        v[k] = v[k-1];
        k--;
      end
      v[k] = tmp;
    end
    e.mem = v;
`ifdef SORT_EARLY_EXIT_EN
    passes = (need + 1 < D - 1) ? need + 1 : D - 1;
`else
    passes = D - 1;
`endif
    e.count = 0;
    for (int p = 0; p < passes; p++) e.count += D - 1 - p;
    return e;
  endfunction

  task automatic load_main(input logic [31:0] v [D]);
    for (int k = 0; k < D; k++) begin
      wr_en = 1'b1; wr_addr = 3'(k); wr_data = v[k];
      @(negedge clk);
      tb_mem[k] = v[k];
    end
    wr_en = 1'b0;
  endtask

  task automatic read_main(input string tag, input logic [31:0] exp_m [D]);
    chk({tag, "_pt"}, point, pt);
    for (int k = 0; k < D; k++) begin
      chk(tag, data0, exp_m[pt]);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      pt = (pt + 1) % D;
    end
  endtask

  task automatic run_sort(input string tag, input logic up_v, input bit poke_busy, input bit poke_start);
    exp_t e;
    int   cyc, done_at;
    sb.push_back(model(up_v));
    start = 1'b1; up = up_v;
    if (poke_start) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hDEAD_BEEF; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    cyc = 0; done_at = 0;
    for (int t = 1; t <= 200; t++) begin
      if (busy) cyc++;
      if (done) begin done_at = t; break; end
      if (poke_busy && t == 3) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0000_1234; end
      else wr_en = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done_at"}, done_at, e.count + 1);
    chk({tag, "_busy_cyc"}, cyc, e.count);
    chk({tag, "_count"}, count, e.count);
    chk({tag, "_swaps"}, swaps, e.swaps);
    read_main({tag, "_mem"}, e.mem);
  endtask

  initial begin
    logic [31:0] v [D];
    logic [31:0] s_in [4];
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    logic [31:0] zero [D];
    int          t;

    rst = 1'b1;
    start = 0; up = 0; wr_en = 0; prior = 0; next = 0; wr_addr = '0; wr_data = '0;
    s_start = 0; s_up = 0; s_wr_en = 0; s_prior = 0; s_next = 0; s_wr_addr = '0; s_wr_data = '0;
    d_prior = 0; d_next = 0;
    pt = 0;
    for (int k = 0; k < D; k++) begin tb_mem[k] = '0; zero[k] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_swaps", swaps, 0);
    chk("rst_point", point, 0);
    chk("rst_data0", data0, 0);

    // reverse input, ascending
    v = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    load_main(v);
    run_sort("rev", 1'b1, 0, 0);

    // pointer wrap and cancel on sorted {0..7}
    prior = 1'b1; @(negedge clk); prior = 1'b0;
    chk("ptr_prior", point, 7);
    chk("ptr_prior_d0", data0, 7);
    next = 1'b1; @(negedge clk); next = 1'b0;
    chk("ptr_next", point, 0);
    chk("ptr_next_d0", data0, 0);
    prior = 1'b1; next = 1'b1; @(negedge clk); prior = 1'b0; next = 1'b0;
    chk("ptr_both", point, 0);
    pt = 0;

    // already sorted input
    v = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    load_main(v);
    run_sort("sorted", 1'b1, 0, 0);

    // descending with duplicates and a write attempted while busy
    v = '{32'd3, 32'd3, 32'd1, 32'd5, 32'd9, 32'd0, 32'd5, 32'd2};
    load_main(v);
    run_sort("desc", 1'b0, 1, 0);

    // start and write in the same cycle: write dropped
    for (int k = 0; k < D; k++) v[k] = $urandom_range(0, 15);
    load_main(v);
    run_sort("start_wr", 1'b1, 0, 1);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < D; k++) v[k] = $urandom_range(0, 7);
      load_main(v);
      run_sort($sformatf("rand%0d", r), r[0], 0, 0);
    end

    // signed vs unsigned compare at DEPTH=4
    s_in  = '{32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    exp_s = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
    exp_u = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int k = 0; k < 4; k++) begin
      s_wr_en = 1'b1; s_wr_addr = 2'(k); s_wr_data = s_in[k];
      @(negedge clk);
    end
    s_wr_en = 1'b0;
    s_start = 1'b1; s_up = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    t = 0;
    while (!(sg_done && un_done) && t < 50) begin @(negedge clk); t++; end
    chk("s4_timeout", t < 50, 1);
    chk("s4_sg_count", sg_count, 6);
    chk("s4_un_count", un_count, 6);
    for (int k = 0; k < 4; k++) begin
      chk("s4_sg_mem", sg_data0, exp_s[k]);
      chk("s4_un_mem", un_data0, exp_u[k]);
      s_next = 1'b1; @(negedge clk); s_next = 1'b0;
    end

    // DEPTH=5 pointer wrap
    d_prior = 1'b1; @(negedge clk); d_prior = 1'b0;
    chk("d5_prior", d_point, 4);
    d_next = 1'b1; @(negedge clk); d_next = 1'b0;
    chk("d5_next0", d_point, 0);
    for (int k = 0; k < 4; k++) begin d_next = 1'b1; @(negedge clk); d_next = 1'b0; end
    chk("d5_at4", d_point, 4);
    d_next = 1'b1; @(negedge clk); d_next = 1'b0;
    chk("d5_wrap", d_point, 0);

    // reset at SCAN cycle 10
    for (int k = 0; k < D; k++) v[k] = $urandom_range(1, 200);
    load_main(v);
    start = 1'b1; up = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_count", count, 0);
    chk("mid_swaps", swaps, 0);
    chk("mid_point", point, 0);
    pt = 0;
    for (int k = 0; k < D; k++) tb_mem[k] = '0;
    read_main("mid_mem", zero);

    for (int k = 0; k < D; k++) v[k] = $urandom_range(0, 1000);
    load_main(v);
    run_sort("post_rst", 1'b1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
